// File: rtl/perf_counter_pkg.sv
// Shared register map and control-register layout for the performance counter bank.
package perf_counter_pkg;

  localparam logic [31:0] REG_GLOBAL_CTRL    = 32'h00;
  localparam logic [31:0] REG_OVF_STATUS     = 32'h04;
  localparam logic [31:0] REG_OVF_INT_EN     = 32'h08;
  localparam logic [31:0] REG_COUNTER_BASE   = 32'h10;
  localparam logic [31:0] REG_COUNTER_STRIDE = 32'h10;

  localparam logic [3:0] SUB_CTRL     = 4'h0;
  localparam logic [3:0] SUB_VALUE_LO = 4'h4;
  localparam logic [3:0] SUB_VALUE_HI = 4'h8;

  typedef struct packed {
    logic       enable;
    logic [7:0] event_sel;
  } perf_ctrl_t;

endpackage

// File: rtl/performance_counter_bank_if.sv
// IO bus seen by the counter bank: single-cycle strobes, no ready/valid back-pressure.
interface performance_counter_bank_if;
  // io_write_en / io_read_en are one-cycle strobes qualified by io_address; the bank
  // always accepts them, and read data appears on io_read_data one edge later.
  logic [31:0] io_address;
  logic        io_write_en;
  logic [31:0] io_write_data;
  logic        io_read_en;
  logic [31:0] io_read_data;

  modport master (output io_address, io_write_en, io_write_data, io_read_en,
                  input  io_read_data);
  modport slave  (input  io_address, io_write_en, io_write_data, io_read_en,
                  output io_read_data);
endinterface

// File: rtl/perf_counter_slot.sv
// One event counter with its CTRL register; clear_all > software write > increment.
module perf_counter_slot
  import perf_counter_pkg::*;
#(
  parameter int NUM_EVENTS    = 16,
  parameter int COUNTER_WIDTH = 48
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  global_en,
  input  logic                  clear_all,
  input  logic [NUM_EVENTS-1:0] perf_events,
  input  logic                  ctrl_we,
  input  logic                  lo_we,
  input  logic                  hi_we,
  input  logic [31:0]           wdata,
  output perf_ctrl_t            ctrl,
  output logic [63:0]           value,
  output logic                  wrap
);

  logic [COUNTER_WIDTH-1:0] count_q, count_d;
  perf_ctrl_t               ctrl_q, ctrl_d;
  logic                     event_line;
  logic [63:0]              merged;
  logic [COUNTER_WIDTH:0]   sum;

  always_comb begin
    // Selectors at or above NUM_EVENTS match no line and therefore never count.
    event_line = 1'b0;
    for (int i = 0; i < NUM_EVENTS; i++) begin
      if (ctrl_q.event_sel == i[7:0]) event_line = perf_events[i];
    end

    ctrl_d = ctrl_q;
    if (ctrl_we) begin
      ctrl_d.enable    = wdata[31];
      ctrl_d.event_sel = wdata[7:0];
    end

    merged = 64'(count_q);
    if (lo_we) merged[31:0]  = wdata;
    if (hi_we) merged[63:32] = wdata;

    sum     = {1'b0, count_q} + {{COUNTER_WIDTH{1'b0}}, 1'b1};
    count_d = count_q;
    wrap    = 1'b0;
    if (clear_all) begin
      count_d = '0;
    end else if (lo_we || hi_we) begin
      count_d = merged[COUNTER_WIDTH-1:0];
    end else if (global_en && ctrl_q.enable && event_line) begin
      count_d = sum[COUNTER_WIDTH-1:0];
      wrap    = sum[COUNTER_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      ctrl_q  <= '0;
    end else begin
      count_q <= count_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign ctrl  = ctrl_q;
  assign value = 64'(count_q);

endmodule

// File: rtl/performance_counter_bank.sv
// Memory-mapped bank of event counters: decode, overflow status/interrupt,
// shared high-word shadow for atomic 64-bit reads, and registered read mux.
module performance_counter_bank
  import perf_counter_pkg::*;
#(
  parameter int          NUM_EVENTS    = 16,
  parameter int          NUM_COUNTERS  = 4,
  parameter int          COUNTER_WIDTH = 48,
  parameter logic [31:0] BASE_ADDRESS  = 32'hffff0100
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_EVENTS-1:0]   perf_events,
  performance_counter_bank_if.slave bus,
  output logic                    overflow_int
);

  localparam logic [31:0] MAP_SIZE = 32'(16 + 16 * NUM_COUNTERS);

  logic                    global_en_q, global_en_d;
  logic [NUM_COUNTERS-1:0] ovf_status_q, ovf_status_d;
  logic [NUM_COUNTERS-1:0] ovf_int_en_q, ovf_int_en_d;
  logic [31:0]             hi_shadow_q, hi_shadow_d;
  logic [31:0]             read_data_q, read_data_d;
  logic                    overflow_int_q, overflow_int_d;

  logic [31:0] diff, cnt_off, rd_mux;
  logic [3:0]  sub;
  logic        in_range, cnt_hit, clear_all;
  logic [NUM_COUNTERS-1:0] slot_sel, wrap_vec;
  perf_ctrl_t  ctrl  [NUM_COUNTERS];
  logic [63:0] value [NUM_COUNTERS];

  // Subtracting the base wraps addresses below it to large values, so one compare bounds both ends.
  assign diff      = bus.io_address - BASE_ADDRESS;
  assign in_range  = diff < MAP_SIZE;
  assign cnt_hit   = in_range && (diff >= REG_COUNTER_BASE);
  assign cnt_off   = diff - REG_COUNTER_BASE;
  assign sub       = diff[3:0];
  assign clear_all = bus.io_write_en && in_range && (diff == REG_GLOBAL_CTRL) && bus.io_write_data[1];

  for (genvar k = 0; k < NUM_COUNTERS; k++) begin : g_slot
    assign slot_sel[k] = cnt_hit && (cnt_off[31:4] == 28'(k));

    perf_counter_slot #(
      .NUM_EVENTS   (NUM_EVENTS),
      .COUNTER_WIDTH(COUNTER_WIDTH)
    ) u_slot (
      .clk        (clk),
      .reset      (reset),
      .global_en  (global_en_q),
      .clear_all  (clear_all),
      .perf_events(perf_events),
      .ctrl_we    (bus.io_write_en && slot_sel[k] && (sub == SUB_CTRL)),
      .lo_we      (bus.io_write_en && slot_sel[k] && (sub == SUB_VALUE_LO)),
      .hi_we      (bus.io_write_en && slot_sel[k] && (sub == SUB_VALUE_HI)),
      .wdata      (bus.io_write_data),
      .ctrl       (ctrl[k]),
      .value      (value[k]),
      .wrap       (wrap_vec[k])
    );
  end

  always_comb begin
    global_en_d  = global_en_q;
    ovf_int_en_d = ovf_int_en_q;
    ovf_status_d = ovf_status_q;
    if (bus.io_write_en && in_range && !cnt_hit) begin
      if (diff == REG_GLOBAL_CTRL) global_en_d  = bus.io_write_data[0];
      if (diff == REG_OVF_INT_EN)  ovf_int_en_d = bus.io_write_data[NUM_COUNTERS-1:0];
      if (diff == REG_OVF_STATUS)  ovf_status_d = ovf_status_q & ~bus.io_write_data[NUM_COUNTERS-1:0];
    end
    // A wrap in the same cycle as its W1C wins, so the flag is never lost.
    ovf_status_d   = ovf_status_d | wrap_vec;
    overflow_int_d = |(ovf_status_q & ovf_int_en_q);

    rd_mux      = '0;
    hi_shadow_d = hi_shadow_q;
    if (in_range && !cnt_hit) begin
      if (diff == REG_GLOBAL_CTRL) rd_mux = {31'b0, global_en_q};
      if (diff == REG_OVF_STATUS)  rd_mux = 32'(ovf_status_q);
      if (diff == REG_OVF_INT_EN)  rd_mux = 32'(ovf_int_en_q);
    end
    for (int k = 0; k < NUM_COUNTERS; k++) begin
      if (slot_sel[k]) begin
        case (sub)
          SUB_CTRL:     rd_mux = {ctrl[k].enable, 23'b0, ctrl[k].event_sel};
          SUB_VALUE_LO: begin
            rd_mux = value[k][31:0];
            if (bus.io_read_en) hi_shadow_d = value[k][63:32];
          end
          SUB_VALUE_HI: rd_mux = hi_shadow_q;
          default:      rd_mux = '0;
        endcase
      end
    end
    read_data_d = bus.io_read_en ? rd_mux : read_data_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      global_en_q    <= 1'b0;
      ovf_status_q   <= '0;
      ovf_int_en_q   <= '0;
      hi_shadow_q    <= '0;
      read_data_q    <= '0;
      overflow_int_q <= 1'b0;
    end else begin
      global_en_q    <= global_en_d;
      ovf_status_q   <= ovf_status_d;
      ovf_int_en_q   <= ovf_int_en_d;
      hi_shadow_q    <= hi_shadow_d;
      read_data_q    <= read_data_d;
      overflow_int_q <= overflow_int_d;
    end
  end

  assign bus.io_read_data = read_data_q;
  assign overflow_int     = overflow_int_q;

endmodule

// File: tb/tb_performance_counter_bank.sv
// Self-checking bench for performance_counter_bank (16 events, 4 counters, 48-bit).
module tb_performance_counter_bank;

  localparam logic [31:0] BASE = 32'hffff0100;

  logic        clk;
  logic        reset;
  logic [15:0] perf_events;
  logic        overflow_int;

  logic [31:0] exp_q[$];
  int          n_checks;
  int          n_fail;

  performance_counter_bank_if bus();

  performance_counter_bank #(
    .NUM_EVENTS   (16),
    .NUM_COUNTERS (4),
    .COUNTER_WIDTH(48),
    .BASE_ADDRESS (BASE)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .perf_events (perf_events),
    .bus         (bus),
    .overflow_int(overflow_int)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ctr(input int idx, input int sub);
    return BASE + 32'h10 + 32'(16 * idx) + 32'(sub);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // drivers: every op occupies one active edge, driven and released on negedges
  task automatic bus_op(input logic we, input logic re, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [15:0] ev);
    @(negedge clk);
    bus.io_address    = addr;
    bus.io_write_en   = we;
    bus.io_write_data = wd;
    bus.io_read_en    = re;
    perf_events       = ev;
    @(negedge clk);
    bus.io_write_en   = 1'b0;
    bus.io_read_en    = 1'b0;
    bus.io_write_data = '0;
    perf_events       = '0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] wd);
    bus_op(1'b1, 1'b0, addr, wd, 16'h0);
  endtask

  task automatic events(input logic [15:0] ev, input int n);
    for (int i = 0; i < n; i++) bus_op(1'b0, 1'b0, BASE + 32'h40, 32'h0, ev);
  endtask

  // scoreboard: expectation queued with the stimulus, popped when read data returns
  task automatic rd_op(input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [15:0] ev, input logic [31:0] exp);
    exp_q.push_back(exp);
    bus_op(we, 1'b1, addr, wd, ev);
    check_eq(tag, bus.io_read_data, exp_q.pop_front());
  endtask

  task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    rd_op(tag, 1'b0, addr, 32'h0, 16'h0, exp);
  endtask

  initial begin
    n_checks          = 0;
    n_fail            = 0;
    reset             = 1'b0;
    perf_events       = '0;
    bus.io_address    = '0;
    bus.io_write_en   = 1'b0;
    bus.io_write_data = '0;
    bus.io_read_en    = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // reset mid-count
    wr(BASE + 32'h0, 32'h1);
    wr(ctr(0, 0), 32'h8000_0003);
    wr(BASE + 32'h8, 32'h1);
    events(16'h0008, 3);
    #2 reset = 1'b0;
    #7 reset = 1'b1;
    check_eq("rst_read_data", bus.io_read_data, 32'h0);
    check_eq("rst_ovf_int", {31'b0, overflow_int}, 32'h0);
    rd("rst_global", BASE + 32'h0, 32'h0);
    rd("rst_ctrl0", ctr(0, 0), 32'h0);
    rd("rst_lo0", ctr(0, 4), 32'h0);
    rd("rst_int_en", BASE + 32'h8, 32'h0);

    // global_en=0 blocks counting
    wr(ctr(0, 0), 32'h8000_0003);
    events(16'h0008, 4);
    rd("gen_off_lo0", ctr(0, 4), 32'h0);

    // basic count with distractor event 2
    wr(BASE + 32'h0, 32'h1);
    wr(ctr(1, 0), 32'h8000_0004);
    rd("ctrl0", ctr(0, 0), 32'h8000_0003);
    for (int i = 0; i < 10; i++) events(16'h0008 | 16'($urandom_range(0, 1) << 2), 1);
    rd("lo1_idle", ctr(1, 4), 32'h0);
    rd("lo0_count", ctr(0, 4), 32'd10);
    rd("hi0_count", ctr(0, 8), 32'h0);
    rd("lo2_idle", ctr(2, 4), 32'h0);
    @(negedge clk);
    check_eq("read_hold", bus.io_read_data, 32'h0);
    rd("global_rd", BASE + 32'h0, 32'h1);

    // wrap and interrupt on counter 1 (48-bit), high write bits discarded
    wr(ctr(1, 4), 32'hffff_ffff);
    wr(ctr(1, 8), 32'hffff_ffff);
    rd("wrap_pre_lo", ctr(1, 4), 32'hffff_ffff);
    rd("wrap_pre_hi", ctr(1, 8), 32'h0000_ffff);
    wr(BASE + 32'h8, 32'h2);
    events(16'h0010, 1);
    check_eq("int_not_yet", {31'b0, overflow_int}, 32'h0);
    @(negedge clk);
    check_eq("int_rise", {31'b0, overflow_int}, 32'h1);
    rd("wrap_status", BASE + 32'h4, 32'h2);
    rd("wrap_lo", ctr(1, 4), 32'h0);
    rd("wrap_hi", ctr(1, 8), 32'h0);
    wr(BASE + 32'h4, 32'h2);
    rd("w1c_status", BASE + 32'h4, 32'h0);
    check_eq("int_fall", {31'b0, overflow_int}, 32'h0);

    // atomic 64-bit read through the shadow
    wr(ctr(1, 4), 32'hffff_ffff);
    wr(ctr(1, 8), 32'h1);
    rd_op("atomic_lo", 1'b0, ctr(1, 4), 32'h0, 16'h0010, 32'hffff_ffff);
    rd("atomic_hi", ctr(1, 8), 32'h1);
    rd("atomic_lo2", ctr(1, 4), 32'h0);
    rd("atomic_hi2", ctr(1, 8), 32'h2);

    // W1C colliding with a wrap keeps the flag
    wr(ctr(1, 4), 32'hffff_ffff);
    wr(ctr(1, 8), 32'h0000_ffff);
    bus_op(1'b1, 1'b0, BASE + 32'h4, 32'h2, 16'h0010);
    rd("w1c_vs_wrap", BASE + 32'h4, 32'h2);
    wr(BASE + 32'h4, 32'h2);

    // software write beats an increment
    bus_op(1'b1, 1'b0, ctr(0, 4), 32'd5, 16'h0008);
    rd("lo_write_wins", ctr(0, 4), 32'd5);

    // clear_all beats an increment, leaves CTRL and status alone
    wr(ctr(1, 4), 32'hffff_ffff);
    wr(ctr(1, 8), 32'h0000_ffff);
    bus_op(1'b1, 1'b0, BASE + 32'h0, 32'h3, 16'h0018);
    rd("clr_lo0", ctr(0, 4), 32'h0);
    rd("clr_lo1", ctr(1, 4), 32'h0);
    rd("clr_hi1", ctr(1, 8), 32'h0);
    rd("clr_status", BASE + 32'h4, 32'h0);
    rd("clr_ctrl0", ctr(0, 0), 32'h8000_0003);
    rd("clr_global", BASE + 32'h0, 32'h1);

    // decode: reserved, unmapped, below base, and out-of-range event_sel
    wr(ctr(0, 4), 32'h5);
    rd("rsvd_0c", BASE + 32'hc, 32'h0);
    rd("rsvd_slot_c", ctr(0, 12), 32'h0);
    wr(ctr(4, 4), 32'h7);
    rd("unmapped_slot", ctr(4, 4), 32'h0);
    rd("below_base", BASE - 32'h4, 32'h0);
    rd("lo0_untouched", ctr(0, 4), 32'h5);
    wr(ctr(2, 0), 32'h8000_00c8);
    events(16'hffff, 5);
    rd("sel200_lo2", ctr(2, 4), 32'h0);
    rd("all_ev_lo0", ctr(0, 4), 32'd10);

    // simultaneous write and read returns the pre-write value
    rd_op("rw_same_cycle", 1'b1, ctr(0, 4), 32'h55, 16'h0, 32'd10);
    rd("rw_after", ctr(0, 4), 32'h55);

    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
